// File: rtl/ant_pkg.sv
// Shared move codes, state encoding and move decode for the ant navigation blocks.
package ant_pkg;

  localparam logic [1:0] MV_HALT  = 2'b00;
  localparam logic [1:0] MV_FWD   = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FWD      = 3'd1,
    ST_TURN_IN  = 3'd2,
    ST_TURN_OUT = 3'd3,
    ST_RECOVER  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Turning "in" means toward the followed wall; "out" is away from it.
  function automatic logic [1:0] move_of(input state_e st, input logic left_hand);
    logic [1:0] mv;
    mv = MV_HALT;
    case (st)
      ST_FWD:      mv = MV_FWD;
      ST_TURN_IN:  mv = left_hand ? MV_LEFT : MV_RIGHT;
      ST_TURN_OUT: mv = left_hand ? MV_RIGHT : MV_LEFT;
      default:     mv = MV_HALT;
    endcase
    return mv;
  endfunction

endpackage

// File: rtl/ant_ph_timer.sv
// Forward-step counter and registered pheromone drop pulse.
module ant_ph_timer #(
  parameter int PH_WIDTH  = 2,
  parameter int PH_CODE   = 1,
  parameter int PH_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fwd_i,
  input  logic                suppress_i,
  input  logic [PH_WIDTH-1:0] ph_detected_i,
  output logic [PH_WIDTH-1:0] ph_drop_o
);

  localparam logic [7:0]          STEP_LAST = 8'(PH_PERIOD - 1);
  localparam logic [PH_WIDTH-1:0] CODE      = PH_WIDTH'(PH_CODE);

  logic [7:0]          step_q, step_d;
  logic [PH_WIDTH-1:0] drop_q, drop_d;
  logic                last_step;

  always_comb begin
    last_step = fwd_i && (step_q == STEP_LAST);
    step_d    = step_q;
    drop_d    = '0;
    if (fwd_i) step_d = last_step ? 8'd0 : step_q + 8'd1;
    // An occupied cell still consumes the period; the drop is simply skipped.
    if (last_step && (ph_detected_i == '0) && !suppress_i) drop_d = CODE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= 8'd0;
      drop_q <= '0;
    end else begin
      step_q <= step_d;
      drop_q <= drop_d;
    end
  end

  assign ph_drop_o = drop_q;

endmodule

// File: rtl/ant_nav.sv
// Wall-following ant navigator: antenna-driven FSM with hit recovery, spin limit and pheromone trail.
module ant_nav
  import ant_pkg::*;
#(
  parameter int HAND      = 0,
  parameter int PH_WIDTH  = 2,
  parameter int PH_CODE   = 1,
  parameter int PH_PERIOD = 8,
  parameter int SPIN_MAX  = 4,
  parameter int HIT_WAIT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ant_r,
  input  logic                ant_l,
  input  logic                hit,
  input  logic                escape,
  input  logic [PH_WIDTH-1:0] ph_detected,
  output logic [1:0]          move,
  output logic [PH_WIDTH-1:0] ph_drop,
  output logic                done
);

  localparam logic       LEFT_HAND = (HAND != 0);
  localparam logic [7:0] SPIN_LAST = 8'(SPIN_MAX - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(HIT_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] spin_q, spin_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] move_q;
  logic       done_q;
  logic       f_ant, o_ant, turning;

  always_comb begin
    f_ant   = LEFT_HAND ? ant_l : ant_r;
    o_ant   = LEFT_HAND ? ant_r : ant_l;
    turning = (state_q == ST_TURN_IN) || (state_q == ST_TURN_OUT);
    state_d = state_q;
    wait_d  = wait_q;
    spin_d  = turning ? spin_q + 8'd1 : 8'd0;

    if (state_q == ST_DONE) begin
      state_d = ST_DONE;
    end else if (escape) begin
      state_d = ST_DONE;
    end else if (hit) begin
      state_d = ST_RECOVER;
      wait_d  = WAIT_LOAD;
    end else if (state_q == ST_RECOVER) begin
      if (wait_q != 8'd0) wait_d = wait_q - 8'd1;
      else                state_d = ST_TURN_OUT;
    end else if (turning && (spin_q == SPIN_LAST)) begin
      // Break out of a spin by forcing one forward step.
      state_d = ST_FWD;
      spin_d  = 8'd0;
    end else if (f_ant && o_ant) begin
      state_d = ST_TURN_OUT;
    end else if (f_ant) begin
      state_d = ST_FWD;
    end else if (o_ant) begin
      state_d = ST_TURN_OUT;
    end else begin
      state_d = (state_q == ST_FWD) ? ST_TURN_IN : ST_FWD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      spin_q  <= 8'd0;
      wait_q  <= 8'd0;
      move_q  <= MV_HALT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spin_q  <= spin_d;
      wait_q  <= wait_d;
      move_q  <= move_of(state_d, LEFT_HAND);
      done_q  <= (state_d == ST_DONE);
    end
  end

  ant_ph_timer #(
    .PH_WIDTH (PH_WIDTH),
    .PH_CODE  (PH_CODE),
    .PH_PERIOD(PH_PERIOD)
  ) u_ph_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .fwd_i        (state_q == ST_FWD),
    .suppress_i   (state_d == ST_DONE),
    .ph_detected_i(ph_detected),
    .ph_drop_o    (ph_drop)
  );

  assign move = move_q;
  assign done = done_q;

endmodule

// File: doc/ant_nav.md
ANT_NAV -- requirements
Module: ant_nav

Interface
REQ-001 Parameter HAND, default 0, follow side: 0 = right-hand wall follow, 1 = left-hand.
REQ-002 Parameter PH_WIDTH, default 2, pheromone code width.
REQ-003 Parameter PH_CODE, default 1, code written on a pheromone drop.
REQ-004 Parameter PH_PERIOD, default 8, forward cycles between drops (legal range 1..255).
REQ-005 Parameter SPIN_MAX, default 4, maximum consecutive turn cycles (legal range 1..255).
REQ-006 Parameter HIT_WAIT, default 3, halt cycles after a hit (legal range 1..255).
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-009 ant_r  input  1  right antenna; 1 = wall contact.
REQ-010 ant_l  input  1  left antenna; 1 = wall contact.
REQ-011 hit  input  1  collision pulse.
REQ-012 escape  input  1  maze exit reached.
REQ-013 ph_detected  input  PH_WIDTH  pheromone under ant; 0 = none.
REQ-014 move  output  2  registered move code.
REQ-015 ph_drop  output  PH_WIDTH  registered pheromone drop; 0 = no drop.
REQ-016 done  output  1  registered; 1 while in DONE.

Function
REQ-017 Move codes SHALL be HALT=2'b00, FORWARD=2'b01, LEFT=2'b10, RIGHT=2'b11.
REQ-018 States SHALL be IDLE, FWD, TURN_IN, TURN_OUT, RECOVER, DONE; all outputs are decoded from registered state, with 1-cycle latency from an input to move.
REQ-019 Move decode SHALL be:
- IDLE, RECOVER, DONE -> HALT.
- FWD -> FORWARD.
- TURN_IN -> RIGHT if HAND=0, else LEFT.
- TURN_OUT -> the opposite of TURN_IN.
REQ-020 F (follow antenna) SHALL be ant_r if HAND=0, else ant_l; O is the other antenna.
REQ-021 Next-state priority SHALL be, highest first: DONE is sticky > escape -> DONE > hit -> RECOVER > RECOVER countdown > spin limit > antenna rule.
REQ-022 Antenna rule:
- F=1,O=1 -> TURN_OUT.
- F=1,O=0 -> FWD.
- F=0,O=1 -> TURN_OUT.
- F=0,O=0 -> TURN_IN if current state is FWD; otherwise FWD.
REQ-023 Entering RECOVER SHALL load the wait counter with HIT_WAIT-1.
- While the counter is nonzero, stay in RECOVER and decrement.
- When the counter is 0, go to TURN_OUT.
- A hit while in RECOVER reloads the counter.
REQ-024 The spin counter SHALL increment each cycle spent in TURN_IN or TURN_OUT and clear in every other state.
- When it equals SPIN_MAX-1 and no escape or hit is present, next state is FWD and the counter clears.
REQ-025 The step counter SHALL increment only on cycles in FWD and wrap to 0 after PH_PERIOD-1.
REQ-026 ph_drop SHALL equal PH_CODE for exactly one cycle after a FWD cycle in which the step counter equals PH_PERIOD-1 and ph_detected==0; otherwise ph_drop is 0.
- If ph_detected!=0 on that cycle, no drop occurs and the counter still wraps.
REQ-027 Escape and hit asserted in the same cycle SHALL resolve to DONE.
REQ-028 In DONE, all inputs except rst_n SHALL be ignored; move=HALT, ph_drop=0, done=1.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL load: state=IDLE, move=HALT, ph_drop=0, done=0, and all counters=0.
REQ-030 Reset asserted in any state, including mid-RECOVER or DONE, SHALL take effect at the next edge with no residual count.
REQ-031 The first edge after rst_n rises SHALL evaluate REQ-021 from IDLE.

Structure
REQ-032 Package ant_pkg SHALL hold the move-code constants and the state enumeration, shared with the existing ant blocks and benches.
REQ-033 One sub-module, ant_ph_timer, SHALL implement the step counter and ph_drop register (REQ-025/026); all other logic is in ant_nav.

Verification
REQ-034 HAND=0, ant_r=1, ant_l=0 held 10 cycles after reset -> move HALT for 1 cycle, then FORWARD.
REQ-035 FWD, then ant_r=ant_l=0 -> one RIGHT cycle, then FORWARD; repeat with HAND=1 -> LEFT.
REQ-036 ant_r=ant_l=1 held, SPIN_MAX=4 -> LEFT x4, FORWARD x1, LEFT x4, and so on.
REQ-037 hit pulse during FWD, HIT_WAIT=3 -> HALT x3, then one TURN_OUT cycle; hit re-pulsed at the 2nd HALT -> 3 more HALT cycles from that point.
REQ-038 Continuous FWD, PH_PERIOD=8, ph_detected=0 -> ph_drop=1 on cycles 9, 17, ...; with ph_detected=2 -> ph_drop stays 0.
REQ-039 escape and hit in the same cycle -> done=1, move=HALT sticky; rst_n=0 for one edge -> IDLE, done=0.
